seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial bit-pattern detector with a runtime-loadable pattern, selectable overlapping or non-overlapping detection, and a saturating match counter. It consumes a qualified serial bit stream, one bit per valid cycle. It emits a combinational Mealy match pulse on the cycle the final pattern bit arrives, plus a registered copy. It sits in the same serial-input datapath as the team's fixed-pattern detectors and replaces hard-coded 4-bit FSMs.

## Interface
- PAT_LEN, 4: pattern length in bits; legal range 2..16.
- PATTERN, 4'b1001: reset/default pattern; MSB is the first bit received.
- CNT_W, 8: match counter width; legal range 1..32.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- din  input  1  serial data bit.
- din_valid  input  1  din is consumed this cycle when high.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every valid cycle.
- cfg_load  input  1  load `pattern` into the pattern register and flush history.
- pattern  input  PAT_LEN  new pattern, used only when cfg_load = 1.
- cnt_clr  input  1  clear match_count.
- match  output  1  Mealy match; combinational from din, din_valid, state.
- match_q  output  1  match registered by one cycle.
- match_count  output  CNT_W  number of matches since reset/clear; saturates at all-ones.

## Operation
State:
- pat_reg[PAT_LEN-1:0]: active pattern.
- hist[PAT_LEN-2:0]: last PAT_LEN-1 accepted bits; the newest bit is the LSB.
- fill: count of accepted bits since the last flush, saturating at PAT_LEN-1.
- match_q and match_count.

Reset:
- pat_reg = PATTERN; hist = 0; fill = 0; match_q = 0; match_count = 0.
- match is forced to 0 while reset = 1.

Match condition:
- match = !reset && !cfg_load && din_valid && fill == PAT_LEN-1 && {hist, din} == pat_reg.

Accepted bit (din_valid = 1, cfg_load = 0, reset = 0):
- If match = 1 and overlap = 0: hist = 0 and fill = 0. The next match needs PAT_LEN fresh bits.
- Otherwise: hist = {hist[PAT_LEN-3:0], din} and fill = min(fill+1, PAT_LEN-1).

din_valid = 0:
- hist and fill hold; match = 0. Gaps of any length are transparent to detection.

cfg_load = 1:
- pat_reg = pattern; hist = 0; fill = 0.
- din is ignored that cycle even if valid.
- match_count is unaffected.

match_count:
- Increments by 1 on each cycle with match = 1.
- Holds at 2^CNT_W-1 once reached.
- cnt_clr = 1 sets it to 0.

Priority, highest first: reset > cfg_load > din_valid processing. For the counter: reset > cnt_clr > increment. If cnt_clr and match occur in the same cycle, the count becomes 0 and that match is not counted.

overlap may change between any two valid bits. Its value on a matching cycle decides whether history is kept.

## Timing
- match: zero latency; asserted in the same cycle as the accepted final pattern bit, for exactly one cycle per match.
- match_q: equals the previous cycle's match; 0 in the cycle after reset or cfg_load.
- match_count: reflects a match in the cycle after it, aligned with match_q.
- Minimum spacing between matches: 1 valid bit in overlap mode for self-overlapping patterns (e.g. 11 with PAT_LEN=2); PAT_LEN valid bits in non-overlap mode.
- Reset mid-pattern: partial history is discarded and pat_reg reverts to PATTERN. No match can occur until PAT_LEN new valid bits have been accepted.

## Test plan
- Overlap, default 1001: valid bits 1,0,0,1,0,0,1 -> match on bits 4 and 7; match_q one cycle later each; match_count = 2.
- Non-overlap, same stream: match on bit 4 only; match_count = 1. Continue with bit 8 = 0 (bits 5–8 = 0,0,1,0, no match), then feed 1,0,0,1 -> match on bit 12; match_count = 2.
- Valid gaps: bits 1,0, three idle cycles, then 0,1 -> single match on the 4th valid bit; match = 0 on every idle cycle.
- Runtime pattern: cfg_load with pattern = 0110 alongside din_valid = 1, din = 1 (that bit is dropped), then overlap stream 0,1,1,0,1,1,0 -> matches on valid bits 4 and 7. Reset -> stream 1,0,0,1 matches again with pattern 1001.
- Counter: CNT_W = 2, overlap, PAT_LEN = 2, pattern 11, six consecutive 1s -> match on bits 2..6 (5 matches); match_count saturates at 3. Assert cnt_clr together with a match -> match_count = 0 on the next cycle.
- Reset mid-operation: after accepting 1,0,0, assert reset for one cycle with din_valid = 1, din = 1 -> no match; match_q = 0; fill = 0 afterwards.

Source files
------------

// File: rtl/seq_detector_param_if.sv
// ============================================================================
// Module   : seq_detector_param_if
// Purpose  : Serial-bit, configuration and match signals for seq_detector_param.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface seq_detector_param_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  logic               din;
  logic               din_valid;
  logic               overlap;
  logic               cfg_load;
  logic [PAT_LEN-1:0] pattern;
  logic               cnt_clr;
  logic               match;
  logic               match_q;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output din, din_valid, overlap, cfg_load, pattern, cnt_clr,
    input  match, match_q, match_count
  );

  modport slave (
    input  din, din_valid, overlap, cfg_load, pattern, cnt_clr,
    output match, match_q, match_count
  );
endinterface

`default_nettype wire

// File: rtl/seq_detector_param.sv
// ============================================================================
// Module   : seq_detector_param
// Purpose  : Runtime-loadable serial pattern detector with overlap control,
//            Mealy match output and a saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seq_detector_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
  parameter int                 CNT_W   = 8
) (
  input  wire logic          clk,
  input  wire logic          reset,
  seq_detector_param_if.slave bus
);

  localparam int                FILL_W     = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] C_FILL_MAX = FILL_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0]  C_CNT_MAX  = '1;

  logic [PAT_LEN-1:0] r_pat;
  logic [PAT_LEN-2:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic               r_match_q;
  logic [CNT_W-1:0]   r_cnt;

  logic [PAT_LEN-1:0] w_window;
  logic               w_match;

  // Newest bit sits at the LSB, so the window lines up with the MSB-first pattern.
  assign w_window = {r_hist, bus.din};
  assign w_match  = !reset && !bus.cfg_load && bus.din_valid &&
                    (r_fill == C_FILL_MAX) && (w_window == r_pat);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat     <= PATTERN;
      r_hist    <= '0;
      r_fill    <= '0;
      r_match_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_match_q <= w_match;

      if (bus.cfg_load) begin
        r_pat  <= bus.pattern;
        r_hist <= '0;
        r_fill <= '0;
      end else if (bus.din_valid) begin
        if (w_match && !bus.overlap) begin
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          r_hist <= w_window[PAT_LEN-2:0];
          if (r_fill != C_FILL_MAX) begin
            r_fill <= r_fill + FILL_W'(1);
          end
        end
      end

      // A match coinciding with a clear is intentionally lost.
      if (bus.cnt_clr) begin
        r_cnt <= '0;
      end else if (w_match && (r_cnt != C_CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.match       = w_match;
  assign bus.match_q     = r_match_q;
  assign bus.match_count = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// ============================================================================
// Module   : tb_seq_detector_param
// Purpose  : Table-driven directed vectors plus randomized queue-model checks.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seq_detector_param;

  typedef struct {
    bit       rst;
    bit       ld;
    bit [3:0] pat;
    bit       v;
    bit       d;
    bit       ovl;
    bit       clr;
    bit       em;
    bit       emq;
    int       ec;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  vec_t ta[$];
  vec_t tb[$];

  // Reference model state for the randomized phase
  bit [3:0] mp;
  bit       hq[$];
  int       mcnt;
  bit       mprev;
  bit       r_r, r_ld, r_v, r_d, r_ovl, r_clr, r_em;
  bit [3:0] r_pat;

  seq_detector_param_if #(.PAT_LEN(4), .CNT_W(8)) ifa ();
  seq_detector_param_if #(.PAT_LEN(2), .CNT_W(2)) ifb ();

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1001), .CNT_W(8)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ifa)
  );

  seq_detector_param #(.PAT_LEN(2), .PATTERN(2'b11), .CNT_W(2)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ifb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rst, bit ld, bit [3:0] pat, bit v, bit d,
                              bit ovl, bit clr, bit em, bit emq, int ec);
    vec_t t;
    t.rst = rst; t.ld = ld; t.pat = pat; t.v = v; t.d = d;
    t.ovl = ovl; t.clr = clr; t.em = em; t.emq = emq; t.ec = ec;
    return t;
  endfunction

  function automatic vec_t bv(bit d, bit ovl, bit em, int ec);
    return mk(1'b0, 1'b0, 4'd0, 1'b1, d, ovl, 1'b0, em, em, ec);
  endfunction

  function automatic vec_t rs();
    return mk(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
  endfunction

  task automatic apply(input vec_t t, input bit sel, input string tag);
    int m, mq, c;
    @(negedge clk);
    if (!sel) begin
      rst_a = t.rst; ifa.cfg_load = t.ld; ifa.pattern = t.pat; ifa.din_valid = t.v;
      ifa.din = t.d; ifa.overlap = t.ovl; ifa.cnt_clr = t.clr;
    end else begin
      rst_b = t.rst; ifb.cfg_load = t.ld; ifb.pattern = t.pat[1:0]; ifb.din_valid = t.v;
      ifb.din = t.d; ifb.overlap = t.ovl; ifb.cnt_clr = t.clr;
    end
    #1;
    m = sel ? int'(ifb.match) : int'(ifa.match);
    chk({tag, " match"}, m, int'(t.em));
    @(posedge clk);
    #1;
    mq = sel ? int'(ifb.match_q) : int'(ifa.match_q);
    c  = sel ? int'(ifb.match_count) : int'(ifa.match_count);
    chk({tag, " match_q"}, mq, int'(t.emq));
    chk({tag, " match_count"}, c, t.ec);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.din = 1'b0; ifa.din_valid = 1'b0; ifa.overlap = 1'b0;
    ifa.cfg_load = 1'b0; ifa.pattern = '0; ifa.cnt_clr = 1'b0;
    ifb.din = 1'b0; ifb.din_valid = 1'b0; ifb.overlap = 1'b0;
    ifb.cfg_load = 1'b0; ifb.pattern = '0; ifb.cnt_clr = 1'b0;

    // Default 1001, overlapping: matches on bits 4 and 7
    ta.push_back(rs());
    ta.push_back(bv(1, 1, 0, 0)); ta.push_back(bv(0, 1, 0, 0));
    ta.push_back(bv(0, 1, 0, 0)); ta.push_back(bv(1, 1, 1, 1));
    ta.push_back(bv(0, 1, 0, 1)); ta.push_back(bv(0, 1, 0, 1));
    ta.push_back(bv(1, 1, 1, 2));
    // Non-overlapping: match on bit 4, none on 5-8, then bit 12
    ta.push_back(rs());
    ta.push_back(bv(1, 0, 0, 0)); ta.push_back(bv(0, 0, 0, 0));
    ta.push_back(bv(0, 0, 0, 0)); ta.push_back(bv(1, 0, 1, 1));
    ta.push_back(bv(0, 0, 0, 1)); ta.push_back(bv(0, 0, 0, 1));
    ta.push_back(bv(1, 0, 0, 1)); ta.push_back(bv(0, 0, 0, 1));
    ta.push_back(bv(1, 0, 0, 1)); ta.push_back(bv(0, 0, 0, 1));
    ta.push_back(bv(0, 0, 0, 1)); ta.push_back(bv(1, 0, 1, 2));
    // Idle gaps are transparent
    ta.push_back(rs());
    ta.push_back(bv(1, 1, 0, 0)); ta.push_back(bv(0, 1, 0, 0));
    for (int k = 0; k < 3; k++) ta.push_back(mk(0, 0, 4'd0, 0, 1, 1, 0, 0, 0, 0));
    ta.push_back(bv(0, 1, 0, 0)); ta.push_back(bv(1, 1, 1, 1));
    ta.push_back(mk(0, 0, 4'd0, 0, 0, 1, 1, 0, 0, 0));
    // Runtime load of 0110 with a dropped valid bit, then overlapping stream
    ta.push_back(mk(0, 1, 4'b0110, 1, 1, 1, 0, 0, 0, 0));
    ta.push_back(bv(0, 1, 0, 0)); ta.push_back(bv(1, 1, 0, 0));
    ta.push_back(bv(1, 1, 0, 0)); ta.push_back(bv(0, 1, 1, 1));
    ta.push_back(bv(1, 1, 0, 1)); ta.push_back(bv(1, 1, 0, 1));
    ta.push_back(bv(0, 1, 1, 2));
    // Reset restores 1001; reset mid-pattern discards partial history
    ta.push_back(rs());
    ta.push_back(bv(1, 1, 0, 0)); ta.push_back(bv(0, 1, 0, 0));
    ta.push_back(bv(0, 1, 0, 0));
    ta.push_back(rs());
    ta.push_back(bv(1, 1, 0, 0)); ta.push_back(bv(0, 1, 0, 0));
    ta.push_back(bv(0, 1, 0, 0)); ta.push_back(bv(1, 1, 1, 1));

    // PAT_LEN=2, pattern 11, CNT_W=2: saturation, clear-with-match, non-overlap spacing
    tb.push_back(rs());
    tb.push_back(bv(1, 1, 0, 0)); tb.push_back(bv(1, 1, 1, 1));
    tb.push_back(bv(1, 1, 1, 2)); tb.push_back(bv(1, 1, 1, 3));
    tb.push_back(bv(1, 1, 1, 3)); tb.push_back(bv(1, 1, 1, 3));
    tb.push_back(mk(0, 0, 4'd0, 1, 1, 1, 1, 1, 1, 0));
    tb.push_back(bv(1, 1, 1, 1));
    tb.push_back(bv(1, 0, 1, 2)); tb.push_back(bv(1, 0, 0, 2));
    tb.push_back(bv(1, 0, 1, 3));

    foreach (ta[i]) apply(ta[i], 1'b0, $sformatf("A%0d", i));
    foreach (tb[i]) apply(tb[i], 1'b1, $sformatf("B%0d", i));

    // Randomized phase against a queue-based model of the accepted bits
    mp = 4'b1001; hq.delete(); mcnt = 0; mprev = 1'b0; r_ovl = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r_r   = (i == 0) || ($urandom_range(0, 199) == 0);
      r_ld  = ($urandom_range(0, 39) == 0);
      r_pat = 4'($urandom);
      r_v   = ($urandom_range(0, 3) != 0);
      r_d   = 1'($urandom);
      if ($urandom_range(0, 7) == 0) r_ovl = ~r_ovl;
      r_clr = ($urandom_range(0, 49) == 0);
      rst_a = r_r; ifa.cfg_load = r_ld; ifa.pattern = r_pat; ifa.din_valid = r_v;
      ifa.din = r_d; ifa.overlap = r_ovl; ifa.cnt_clr = r_clr;
      #1;
      r_em = 1'b0;
      if (!r_r && !r_ld && r_v && hq.size() == 3)
        r_em = ({hq[0], hq[1], hq[2], r_d} == mp);
      chk("rnd match", int'(ifa.match), int'(r_em));
      @(posedge clk);
      #1;
      if (r_r) begin
        mp = 4'b1001; hq.delete(); mcnt = 0; mprev = 1'b0;
      end else begin
        mprev = r_em;
        if (r_ld) begin
          mp = r_pat; hq.delete();
        end else if (r_v) begin
          if (r_em && !r_ovl) hq.delete();
          else begin
            hq.push_back(r_d);
            if (hq.size() > 3) void'(hq.pop_front());
          end
        end
        if (r_clr) mcnt = 0;
        else if (r_em && mcnt < 255) mcnt++;
      end
      chk("rnd match_q", int'(ifa.match_q), int'(mprev));
      chk("rnd match_count", int'(ifa.match_count), mcnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
